// File: rtl/sfu_writeback.sv
// Drains the SFU accumulator bank into the output SRAM, one 8-lane word per RD/CAP/WR triplet.
// Define SFU_RELU_EN to clamp negative lanes to zero on the way through; otherwise lanes pass unchanged.
module sfu_writeback #(
  parameter int NCH       = 8,
  parameter int BW        = 16,
  parameter int NWORDS    = 16,
  parameter int RD_AW     = 4,
  parameter int SRAM_AW   = 11,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  rd_en,
  output logic [RD_AW-1:0]      rd_addr,
  input  logic [NCH*BW-1:0]     rd_data,
  output logic                  wr_en,
  output logic [SRAM_AW-1:0]    wr_addr,
  output logic [NCH*BW-1:0]     wr_data,
  input  logic                  wr_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_clear
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  localparam logic [RD_AW-1:0]   LAST_IDX = RD_AW'(NWORDS - 1);
  localparam logic [SRAM_AW-1:0] BASE     = SRAM_AW'(BASE_ADDR);

  state_t              state_q, state_d;
  logic [RD_AW-1:0]    idx_q, idx_d;
  logic [NCH*BW-1:0]   hold_q, hold_d;
  logic [NCH*BW-1:0]   f_data;

  // Per-lane element function applied between the bank and the holding register.
  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_lane
`ifdef SFU_RELU_EN
      assign f_data[BW*gi +: BW] = rd_data[BW*gi + BW - 1] ? '0 : rd_data[BW*gi +: BW];
`else
      assign f_data[BW*gi +: BW] = rd_data[BW*gi +: BW];
`endif
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD;
          idx_d   = '0;
        end
      end
      S_RD:  state_d = S_CAP;
      S_CAP: begin
        hold_d  = f_data;
        state_d = S_WR;
      end
      S_WR: begin
        if (wr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + RD_AW'(1);
            state_d = S_RD;
          end
        end
      end
      S_DONE: begin
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  // Outputs depend on registered state only; addresses are gated so idle outputs read zero.
  assign rd_en     = (state_q == S_RD);
  assign rd_addr   = (state_q == S_RD) ? idx_q : '0;
  assign wr_en     = (state_q == S_WR);
  assign wr_addr   = (state_q == S_WR) ? (BASE + SRAM_AW'(idx_q)) : '0;
  assign wr_data   = (state_q == S_WR) ? hold_q : '0;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign acc_clear = (state_q == S_DONE);

endmodule
